// File: rtl/counter_up_down_param.sv
// counter_up_down_param: prescaled up/down counter with run/stop, clear, load.
// In: clk, reset (async, low), enable, mode, clear, load, load_value. Out: count, tick, wrap, running.
`timescale 1ns/1ps
module counter_up_down_param #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 10,
  parameter int MAX_COUNT   = 9999,
  parameter int WIDTH       = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap,
  output logic             running
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0]    DIV_LAST = DW'(DIV - 1);
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MAX_COUNT);

  logic [DW-1:0]    div_cnt;
  logic [DW-1:0]    div_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] load_sat;
  logic             tick_nxt;
  logic             wrap_nxt;
  logic             step;

  // Out-of-range load values clamp to the terminal value.
  always_comb begin
    load_sat = load_value;
    if (load_value > MAX_VAL) begin
      load_sat = MAX_VAL;
    end
  end

  // A registered tick only counts if the counter is still enabled.
  assign step = tick & enable & ~clear & ~load;

  always_comb begin
    div_nxt  = div_cnt;
    tick_nxt = 1'b0;
    if (clear) begin
      div_nxt = '0;
    end else if (enable) begin
      if (div_cnt == DIV_LAST) begin
        div_nxt  = '0;
        tick_nxt = 1'b1;
      end else begin
        div_nxt = div_cnt + DW'(1);
      end
    end
  end

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (clear) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = load_sat;
    end else if (step) begin
      if (!mode) begin
        if (count == MAX_VAL) begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          count_nxt = MAX_VAL;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      count   <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      running <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      count   <= count_nxt;
      tick    <= tick_nxt;
      wrap    <= wrap_nxt;
      running <= enable;
    end
  end

endmodule

// File: tb/tb_counter_up_down_param.sv
// tb_counter_up_down_param: directed scoreboard bench, DIV=10, MAX_COUNT=9.
// Driver queues expected samples per cycle; monitors pop and compare.
`timescale 1ns/1ps
module tb_counter_up_down_param;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         mode;
  logic         clear;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         tick;
  logic         wrap;
  logic         running;

  typedef struct {
    int           cyc;
    logic [W-1:0] count;
    logic         tick;
    logic         wrap;
    logic         running;
    string        name;
  } exp_t;

  exp_t sq[$];
  exp_t aq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  counter_up_down_param #(
    .CLK_FREQ_HZ(100),
    .TICK_HZ    (10),
    .MAX_COUNT  (9)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .clear     (clear),
    .load      (load),
    .load_value(load_value),
    .count     (count),
    .tick      (tick),
    .wrap      (wrap),
    .running   (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input exp_t e);
    checks++;
    if (count !== e.count || tick !== e.tick ||
        wrap !== e.wrap || running !== e.running) begin
      errors++;
      $display("FAIL %s (cyc %0d): got count=%0d tick=%b wrap=%b run=%b, want count=%0d tick=%b wrap=%b run=%b",
               e.name, cyc, count, tick, wrap, running,
               e.count, e.tick, e.wrap, e.running);
    end
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      exp_t e;
      e = sq.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: sample for cycle %0d missed, now %0d",
                 e.name, e.cyc, cyc);
      end else begin
        check(e);
      end
    end
  end

  always @(negedge reset) begin
    #1;
    while (aq.size() > 0) begin
      check(aq.pop_front());
    end
  end

  task automatic to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic ex(input int c, input int cnt, input bit t,
                    input bit w, input bit r, input string nm);
    exp_t e;
    e = '{c, W'(cnt), t, w, r, nm};
    sq.push_back(e);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t a;
    reset = 1'b0;
    enable = 1'b0;
    mode = 1'b0;
    clear = 1'b0;
    load = 1'b0;
    load_value = '0;

    to(2);
    ex(3, 0, 0, 0, 0, "reset_state");
    to(3);
    reset = 1'b1;
    enable = 1'b1;
    ex(4, 0, 0, 0, 1, "run_start");
    ex(12, 0, 0, 0, 1, "pre_tick1");
    ex(13, 0, 1, 0, 1, "tick1");
    ex(14, 1, 0, 0, 1, "step1");
    ex(22, 1, 0, 0, 1, "pre_tick2");
    ex(23, 1, 1, 0, 1, "tick2");
    ex(24, 2, 0, 0, 1, "step2");

    to(24);
    load = 1'b1;
    load_value = 4'd8;
    ex(25, 8, 0, 0, 1, "load8");
    to(25);
    load = 1'b0;
    ex(33, 8, 1, 0, 1, "tick_at8");
    ex(34, 9, 0, 0, 1, "up_to9");
    ex(43, 9, 1, 0, 1, "tick_at9");
    ex(44, 0, 0, 1, 1, "up_wrap");
    ex(45, 0, 0, 0, 1, "up_wrap_end");

    to(45);
    load = 1'b1;
    load_value = 4'd1;
    mode = 1'b1;
    ex(46, 1, 0, 0, 1, "load1");
    to(46);
    load = 1'b0;
    ex(53, 1, 1, 0, 1, "tick_at1");
    ex(54, 0, 0, 0, 1, "down_to0");
    ex(63, 0, 1, 0, 1, "tick_at0");
    ex(64, 9, 0, 1, 1, "down_wrap");
    ex(65, 9, 0, 0, 1, "down_wrap_end");

    to(67);
    mode = 1'b0;
    ex(73, 9, 1, 0, 1, "tick_flip");
    ex(74, 0, 0, 1, 1, "flip_up_wrap");
    ex(75, 0, 0, 0, 1, "flip_wrap_end");
    to(77);
    mode = 1'b1;
    to(80);
    mode = 1'b0;
    ex(83, 0, 1, 0, 1, "tick_flip2");
    ex(84, 1, 0, 0, 1, "flip_twice_up");

    to(84);
    load = 1'b1;
    load_value = 4'd7;
    ex(85, 7, 0, 0, 1, "load7");
    to(85);
    load_value = 4'd15;
    ex(86, 9, 0, 0, 1, "load_sat");
    to(86);
    clear = 1'b1;
    load_value = 4'd5;
    ex(87, 0, 0, 0, 1, "clear_over_load");
    to(87);
    clear = 1'b0;
    load = 1'b0;
    ex(93, 0, 0, 0, 1, "prescaler_cleared");
    ex(97, 0, 1, 0, 1, "tick_after_clear");
    ex(98, 1, 0, 0, 1, "step_after_clear");

    to(101);
    enable = 1'b0;
    ex(102, 1, 0, 0, 0, "hold_start");
    ex(107, 1, 0, 0, 0, "hold_no_tick");
    to(110);
    load = 1'b1;
    load_value = 4'd3;
    ex(111, 3, 0, 0, 0, "load_disabled");
    to(111);
    load = 1'b0;
    ex(121, 3, 0, 0, 0, "hold_end");
    to(121);
    enable = 1'b1;
    ex(122, 3, 0, 0, 1, "resume");
    ex(126, 3, 0, 0, 1, "resume_pre_tick");
    ex(127, 3, 1, 0, 1, "resume_tick");
    ex(128, 4, 0, 0, 1, "resume_step");
    ex(137, 4, 1, 0, 1, "tick_before_drop");
    to(137);
    enable = 1'b0;
    ex(138, 4, 0, 0, 0, "step_discarded");
    to(138);
    enable = 1'b1;
    ex(147, 4, 0, 0, 1, "pre_tick_after_drop");
    ex(148, 4, 1, 0, 1, "tick_after_drop");
    ex(149, 5, 0, 0, 1, "step_after_drop");
    ex(155, 5, 0, 0, 1, "pre_reset");

    to(155);
    #2;
    a = '{0, W'(0), 1'b0, 1'b0, 1'b0, "async_reset"};
    aq.push_back(a);
    reset = 1'b0;
    ex(156, 0, 0, 0, 0, "reset_held");
    to(157);
    reset = 1'b1;
    ex(158, 0, 0, 0, 1, "restart");
    ex(166, 0, 0, 0, 1, "restart_pre_tick");
    ex(167, 0, 1, 0, 1, "restart_tick");
    ex(168, 1, 0, 0, 1, "restart_step");

    to(170);
    #2;
    checks++;
    if (sq.size() + aq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d sync and %0d async samples left, want 0",
               sq.size(), aq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
